video_timing_pattern: RTL

- Upstream source stage for the LCD pipeline, driven by the divided pixel clock.
- Generates the panel timing (hs/vs/de) plus one of four selectable test patterns. Its output feeds the OSD overlay stage, which then drives the LCD pins.
- Also exports active-area pixel coordinates and a frame-start pulse for downstream overlay logic.

---
 rtl/vtp_pkg.sv | 54 +++++
 rtl/video_timing_core.sv | 105 ++++++++++
 rtl/video_timing_pattern.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vtp_pkg.sv
// Shared types and constants for the video timing / test pattern source.
// Optional feature macro: PATTERN_ANIM_EN (moving-box pattern).
package vtp_pkg;

    localparam int unsigned H_W = 11;
    localparam int unsigned V_W = 10;
    localparam int unsigned C_W = 8;

    // Default timing for the 480x272 panel
    localparam int unsigned DEF_H_ACTIVE = 480;
    localparam int unsigned DEF_H_FP     = 2;
    localparam int unsigned DEF_H_SYNC   = 41;
    localparam int unsigned DEF_H_BP     = 2;
    localparam int unsigned DEF_V_ACTIVE = 272;
    localparam int unsigned DEF_V_FP     = 2;
    localparam int unsigned DEF_V_SYNC   = 10;
    localparam int unsigned DEF_V_BP     = 2;
`ifdef PATTERN_ANIM_EN
    localparam int unsigned DEF_BOX_SIZE = 32;
`endif

    typedef enum logic [1:0] {
        PAT_BAR  = 2'd0,
        PAT_GRID = 2'd1,
        PAT_GRAD = 2'd2,
        PAT_BOX  = 2'd3
    } pattern_e;

    typedef struct packed {
        logic [C_W-1:0] r;
        logic [C_W-1:0] g;
        logic [C_W-1:0] b;
    } rgb_t;

    localparam rgb_t RGB_WHITE = 24'hFF_FF_FF;
    localparam rgb_t RGB_BLACK = 24'h00_00_00;

    // Colour bars, left to right
    localparam rgb_t BAR_TABLE [8] = '{
        24'hFF_FF_FF,   // white
        24'hFF_FF_00,   // yellow
        24'h00_FF_FF,   // cyan
        24'h00_FF_00,   // green
        24'hFF_00_FF,   // magenta
        24'hFF_00_00,   // red
        24'h00_00_FF,   // blue
        24'h00_00_00    // black
    };

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        return BAR_TABLE[idx];
    endfunction

endpackage

// File: rtl/video_timing_core.sv
// Panel timing generator: h/v counters, sync/enable decode, active coordinates
// and frame-start pulse, all registered one cycle after the counter state.
module video_timing_core
    import vtp_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic           pclk,
    input  logic           rst_n,
    output logic [H_W-1:0] o_h_cnt_c,
    output logic [V_W-1:0] o_v_cnt_c,
    output logic           o_de_c,
    output logic           o_hs,
    output logic           o_vs,
    output logic           o_de,
    output logic [H_W-1:0] o_pix_x,
    output logic [V_W-1:0] o_pix_y,
    output logic           o_frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;
    logic           r_hs;
    logic           r_vs;
    logic           r_de;
    logic [H_W-1:0] r_pix_x;
    logic [V_W-1:0] r_pix_y;
    logic           r_frame_start;

    logic w_h_last;
    logic w_v_last;
    logic w_hs_act;
    logic w_vs_act;
    logic w_de;
    logic w_first;

    // Decode the current counter state
    always_comb begin
        w_h_last = (r_h_cnt == H_W'(H_TOTAL - 1));
        w_v_last = (r_v_cnt == V_W'(V_TOTAL - 1));
        w_hs_act = (r_h_cnt >= H_W'(HS_START)) && (r_h_cnt < H_W'(HS_END));
        w_vs_act = (r_v_cnt >= V_W'(VS_START)) && (r_v_cnt < V_W'(VS_END));
        w_de     = (r_h_cnt < H_W'(H_ACTIVE)) && (r_v_cnt < V_W'(V_ACTIVE));
        w_first  = (r_h_cnt == '0) && (r_v_cnt == '0);
    end

    // Pixel and line counters; the line counter steps on pixel wrap
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + V_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + H_W'(1);
        end
    end

    // Registered timing outputs, one cycle behind the counters
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs          <= ~HS_POL;
            r_vs          <= ~VS_POL;
            r_de          <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_hs          <= w_hs_act ? HS_POL : ~HS_POL;
            r_vs          <= w_vs_act ? VS_POL : ~VS_POL;
            r_de          <= w_de;
            r_pix_x       <= w_de ? r_h_cnt : '0;
            r_pix_y       <= w_de ? r_v_cnt : '0;
            r_frame_start <= w_first;
        end
    end

    assign o_h_cnt_c     = r_h_cnt;
    assign o_v_cnt_c     = r_v_cnt;
    assign o_de_c        = w_de;
    assign o_hs          = r_hs;
    assign o_vs          = r_vs;
    assign o_de          = r_de;
    assign o_pix_x       = r_pix_x;
    assign o_pix_y       = r_pix_y;
    assign o_frame_start = r_frame_start;

endmodule

// File: rtl/video_timing_pattern.sv
// LCD source stage: panel timing plus four selectable test patterns.
// Optional feature macro: PATTERN_ANIM_EN (moving box; otherwise pattern 3 is mid-gray).
module video_timing_pattern
    import vtp_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
`ifdef PATTERN_ANIM_EN
    ,
    parameter int unsigned BOX_SIZE = DEF_BOX_SIZE
`endif
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic [1:0]       pattern_sel,
    output logic             hs,
    output logic             vs,
    output logic             de,
    output logic [C_W-1:0]   rgb_r,
    output logic [C_W-1:0]   rgb_g,
    output logic [C_W-1:0]   rgb_b,
    output logic [H_W-1:0]   pix_x,
    output logic [V_W-1:0]   pix_y,
    output logic             frame_start
);

    localparam int unsigned STRIPE_W = H_ACTIVE / 8;

    logic [H_W-1:0] w_h;
    logic [V_W-1:0] w_v;
    logic           w_de_c;
    logic           w_first_c;
    pattern_e       w_pat;
    pattern_e       r_pat;
    logic [2:0]     w_stripe;
    rgb_t           w_rgb;
    rgb_t           r_rgb;

    video_timing_core #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL)
    ) u_core (
        .pclk          (pclk),
        .rst_n         (rst_n),
        .o_h_cnt_c     (w_h),
        .o_v_cnt_c     (w_v),
        .o_de_c        (w_de_c),
        .o_hs          (hs),
        .o_vs          (vs),
        .o_de          (de),
        .o_pix_x       (pix_x),
        .o_pix_y       (pix_y),
        .o_frame_start (frame_start)
    );

    // The first pixel of a frame uses the live selector so the whole frame is consistent
    always_comb begin
        w_first_c = (w_h == '0) && (w_v == '0);
        w_pat     = w_first_c ? pattern_e'(pattern_sel) : r_pat;
    end

    // Pattern latch, sampled once per frame at (0,0)
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat <= PAT_BAR;
        end else if (w_first_c) begin
            r_pat <= pattern_e'(pattern_sel);
        end
    end

    // Colour-bar stripe index from constant boundaries, saturating at 7
    always_comb begin
        w_stripe = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (w_h >= H_W'(k * STRIPE_W)) begin
                w_stripe = 3'(k);
            end
        end
    end

`ifdef PATTERN_ANIM_EN
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BX_MAX  = H_ACTIVE - BOX_SIZE;
    localparam int unsigned BY_MAX  = V_ACTIVE - BOX_SIZE;

    logic [H_W-1:0] r_bx;
    logic [V_W-1:0] r_by;
    logic           r_dx;
    logic           r_dy;
    logic [H_W-1:0] w_bx_nxt;
    logic [V_W-1:0] w_by_nxt;
    logic           w_dx_nxt;
    logic           w_dy_nxt;
    logic           w_frame_end_c;
    logic           w_in_box;

    // Bounce step per axis: flip at the limit and step the new way
    always_comb begin
        w_frame_end_c = (w_h == H_W'(H_TOTAL - 1)) && (w_v == V_W'(V_TOTAL - 1));
        w_bx_nxt = r_bx;
        w_dx_nxt = r_dx;
        w_by_nxt = r_by;
        w_dy_nxt = r_dy;
        if (r_dx) begin
            if (r_bx >= H_W'(BX_MAX)) begin
                w_dx_nxt = 1'b0;
                w_bx_nxt = r_bx - H_W'(1);
            end else begin
                w_bx_nxt = r_bx + H_W'(1);
            end
        end else begin
            if (r_bx == '0) begin
                w_dx_nxt = 1'b1;
                w_bx_nxt = r_bx + H_W'(1);
            end else begin
                w_bx_nxt = r_bx - H_W'(1);
            end
        end
        if (r_dy) begin
            if (r_by >= V_W'(BY_MAX)) begin
                w_dy_nxt = 1'b0;
                w_by_nxt = r_by - V_W'(1);
            end else begin
                w_by_nxt = r_by + V_W'(1);
            end
        end else begin
            if (r_by == '0) begin
                w_dy_nxt = 1'b1;
                w_by_nxt = r_by + V_W'(1);
            end else begin
                w_by_nxt = r_by - V_W'(1);
            end
        end
        w_in_box = (w_h >= r_bx) && (w_h < r_bx + H_W'(BOX_SIZE)) &&
                   (w_v >= r_by) && (w_v < r_by + V_W'(BOX_SIZE));
    end

    // Box position moves only on the last blanking cycle of a frame
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_bx <= '0;
            r_by <= '0;
            r_dx <= 1'b1;
            r_dy <= 1'b1;
        end else if (w_frame_end_c) begin
            r_bx <= w_bx_nxt;
            r_by <= w_by_nxt;
            r_dx <= w_dx_nxt;
            r_dy <= w_dy_nxt;
        end
    end
`endif

    // Pattern colour for the current counter position
    always_comb begin
        w_rgb = RGB_BLACK;
        case (w_pat)
            PAT_BAR: w_rgb = bar_colour(w_stripe);
            PAT_GRID: begin
                if ((w_h[3:0] == 4'd0) || (w_v[3:0] == 4'd0)) begin
                    w_rgb = RGB_WHITE;
                end
            end
            PAT_GRAD: begin
                w_rgb.r = w_h[8:1];
                w_rgb.g = w_v[8:1];
                w_rgb.b = 8'h80;
            end
            PAT_BOX: begin
`ifdef PATTERN_ANIM_EN
                w_rgb = w_in_box ? RGB_WHITE : rgb_t'(24'h00_00_40);
`else
                w_rgb = rgb_t'(24'h80_80_80);
`endif
            end
        endcase
    end

    // Registered colour, blanked outside active video
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= RGB_BLACK;
        end else begin
            r_rgb <= w_de_c ? w_rgb : RGB_BLACK;
        end
    end

    assign rgb_r = r_rgb.r;
    assign rgb_g = r_rgb.g;
    assign rgb_b = r_rgb.b;

endmodule
